// File: rtl/sram_qsys_gpio_pio.sv
// Avalon-MM GPIO slave: per-bit direction, 2-flop input sync, armed edge capture, maskable irq.
// Optional atomic OUTSET/OUTCLEAR registers enabled by SRAM_QSYS_GPIO_OUTSETCLR_EN.

module sram_qsys_gpio_pio_lane #(
    parameter int EDGE_TYPE = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin,
    output logic level,
    output logic hit
);
    logic sync1, sync2, prev;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign level = sync2;
    assign hit   = (EDGE_TYPE == 0) ? (sync2 & ~prev) :
                   (EDGE_TYPE == 1) ? (~sync2 & prev) : (sync2 ^ prev);
endmodule

module sram_qsys_gpio_pio #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [WIDTH-1:0] DIR_RESET   = '0,
    parameter int               EDGE_TYPE   = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe,
    output logic             irq
);
    localparam logic [2:0] A_DATA   = 3'd0;
    localparam logic [2:0] A_DIR    = 3'd1;
    localparam logic [2:0] A_MASK   = 3'd2;
    localparam logic [2:0] A_EDGE   = 3'd3;
    localparam logic [2:0] A_OUTSET = 3'd4;
    localparam logic [2:0] A_OUTCLR = 3'd5;

    logic [WIDTH-1:0] data_out, dir, irq_mask, edge_cap;
    logic [WIDTH-1:0] level, hit, wdata, clr;
    logic [1:0]       arm_cnt;
    logic             wr_en, armed;
    logic [31:0]      rd;
    logic             unused_wdata;

    sram_qsys_gpio_pio_lane #(.EDGE_TYPE(EDGE_TYPE)) u_lane [WIDTH-1:0] (
        .clk     (clk),
        .reset_n (reset_n),
        .pin     (in_port),
        .level   (level),
        .hit     (hit)
    );

    assign wr_en        = chipselect & ~write_n;
    assign wdata        = writedata[WIDTH-1:0];
    assign unused_wdata = ^writedata;
    assign clr          = (wr_en && address == A_EDGE) ? wdata : '0;
    // Synchroniser starts from zero, so its first transitions after reset are not real edges.
    assign armed        = (arm_cnt == 2'd3);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_out <= RESET_VALUE;
            dir      <= DIR_RESET;
            irq_mask <= '0;
            edge_cap <= '0;
            arm_cnt  <= 2'd0;
        end else begin
            if (!armed)
                arm_cnt <= arm_cnt + 2'd1;
            edge_cap <= (edge_cap & ~clr) | (armed ? hit : '0);
            if (wr_en) begin
                case (address)
                    A_DATA:   data_out <= wdata;
                    A_DIR:    dir      <= wdata;
                    A_MASK:   irq_mask <= wdata;
`ifdef SRAM_QSYS_GPIO_OUTSETCLR_EN
                    A_OUTSET: data_out <= data_out | wdata;
                    A_OUTCLR: data_out <= data_out & ~wdata;
`endif
                    default:  ;
                endcase
            end
        end
    end

    always_comb begin
        rd = '0;
        case (address)
            A_DATA:  rd[WIDTH-1:0] = (dir & data_out) | (~dir & level);
            A_DIR:   rd[WIDTH-1:0] = dir;
            A_MASK:  rd[WIDTH-1:0] = irq_mask;
            A_EDGE:  rd[WIDTH-1:0] = edge_cap;
            default: rd = '0;
        endcase
    end

    assign readdata = rd;
    assign out_port = data_out;
    assign oe       = dir;
    assign irq      = |(edge_cap & irq_mask);
endmodule

// File: tb/tb_sram_qsys_gpio_pio.sv
// Bench for sram_qsys_gpio_pio: rising-edge and falling-edge instances on a shared bus,
// directed steps followed by random traffic checked against a pin-history model.
module tb_sram_qsys_gpio_pio;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [2:0]  address = 3'd0;
    logic [31:0] writedata = 32'd0;
    logic [7:0]  in_port = 8'd0;
    logic [31:0] rd_a, rd_b;
    logic [7:0]  out_a, out_b, oe_a, oe_b;
    logic        irq_a, irq_b;

    int n_chk = 0;
    int n_pass = 0;

    always #20 clk = ~clk;

    sram_qsys_gpio_pio #(.WIDTH(8), .RESET_VALUE(8'hA5), .DIR_RESET(8'hF0), .EDGE_TYPE(0)) u_rise (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_a),
        .in_port(in_port), .out_port(out_a), .oe(oe_a), .irq(irq_a));

    sram_qsys_gpio_pio #(.WIDTH(8), .RESET_VALUE(8'hA5), .DIR_RESET(8'hF0), .EDGE_TYPE(1)) u_fall (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_b),
        .in_port(in_port), .out_port(out_b), .oe(oe_b), .irq(irq_b));

    // Reference model: register values plus the list of pin samples taken at recent edges.
    logic [7:0] m_dout, m_dir, m_mask;
    logic [7:0] m_cap [2];
    logic [7:0] m_hist [$];
    int         m_since;

    task automatic model_edge();
        logic [7:0] seen, older, clr, ev;
        bit wr;
        if (!reset_n) begin
            m_dout = 8'hA5; m_dir = 8'hF0; m_mask = 8'h00;
            m_cap[0] = 8'h00; m_cap[1] = 8'h00;
            m_hist = '{8'h00, 8'h00, 8'h00};
            m_since = 0;
        end else begin
            wr    = chipselect && !write_n;
            seen  = m_hist[1];   // what DATA currently reports for input pins
            older = m_hist[2];
            clr   = (wr && address == 3'd3) ? writedata[7:0] : 8'h00;
            for (int t = 0; t < 2; t++) begin
                ev = (t == 0) ? (seen & ~older) : (~seen & older);
                if (m_since < 3) ev = 8'h00;
                m_cap[t] = (m_cap[t] & ~clr) | ev;
            end
            if (wr) begin
                if (address == 3'd0) m_dout = writedata[7:0];
                if (address == 3'd1) m_dir  = writedata[7:0];
                if (address == 3'd2) m_mask = writedata[7:0];
`ifdef SRAM_QSYS_GPIO_OUTSETCLR_EN
                if (address == 3'd4) m_dout = m_dout | writedata[7:0];
                if (address == 3'd5) m_dout = m_dout & ~writedata[7:0];
`endif
            end
            m_hist.push_front(in_port);
            void'(m_hist.pop_back());
            m_since++;
        end
    endtask

    function automatic logic [31:0] exp_rd(int t, int a);
        case (a)
            0: return {24'h0, (m_dir & m_dout) | (~m_dir & m_hist[1])};
            1: return {24'h0, m_dir};
            2: return {24'h0, m_mask};
            3: return {24'h0, m_cap[t]};
            default: return 32'h0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic chk_all();
        logic [2:0] save;
        save = address;
        for (int a = 0; a < 8; a++) begin
            address = a[2:0];
            #1;
            check($sformatf("rd_rise[%0d]", a), rd_a, exp_rd(0, a));
            check($sformatf("rd_fall[%0d]", a), rd_b, exp_rd(1, a));
        end
        check("out_port", {24'h0, out_a}, {24'h0, m_dout});
        check("out_port_f", {24'h0, out_b}, {24'h0, m_dout});
        check("oe", {24'h0, oe_a}, {24'h0, m_dir});
        check("oe_f", {24'h0, oe_b}, {24'h0, m_dir});
        check("irq_rise", {31'h0, irq_a}, {31'h0, |(m_cap[0] & m_mask)});
        check("irq_fall", {31'h0, irq_b}, {31'h0, |(m_cap[1] & m_mask)});
        address = save;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk_all();
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        cyc();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a, input bit fall,
                          input logic [31:0] exp);
        address = a;
        #1;
        check(tag, fall ? rd_b : rd_a, exp);
    endtask

    initial begin
        // Reset values
        cyc(); cyc();
        check("rst_out", {24'h0, out_a}, 32'hA5);
        check("rst_oe", {24'h0, oe_a}, 32'hF0);
        check("rst_irq", {31'h0, irq_a}, 32'h0);
        rd_chk("rst_edgecap", 3'd3, 1'b0, 32'h0);
        reset_n = 1'b1;
        cyc();

        // Mixed-direction DATA read
        wr(3'd1, 32'h0F);
        wr(3'd0, 32'h3C);
        in_port = 8'hA0;
        cyc(); cyc(); cyc();
        rd_chk("data_mixed", 3'd0, 1'b0, 32'h000000AC);

        // Rising edge on bit 0 -> capture and irq at edge k+2
        wr(3'd2, 32'h01);
        wr(3'd3, 32'hFF);
        in_port = 8'hA1;
        cyc(); cyc();
        check("irq_early", {31'h0, irq_a}, 32'h0);
        cyc();
        rd_chk("edgecap_b0", 3'd3, 1'b0, 32'h01);
        check("irq_set", {31'h0, irq_a}, 32'h1);
        wr(3'd3, 32'h01);
        check("irq_clr", {31'h0, irq_a}, 32'h0);

        // Pins held high through reset release must not register edges
        in_port = 8'hFF;
        reset_n = 1'b0;
        cyc(); cyc();
        reset_n = 1'b1;
        repeat (6) cyc();
        rd_chk("arm_rise", 3'd3, 1'b0, 32'h0);
        rd_chk("arm_fall", 3'd3, 1'b1, 32'h0);

        // Falling edge on bit 3
        in_port = 8'hF7;
        cyc(); cyc(); cyc();
        rd_chk("fall_b3", 3'd3, 1'b1, 32'h08);

        // Clear and new edge on the same bit in the same cycle: edge wins
        in_port = 8'hFB;
        cyc(); cyc(); cyc();
        wr(3'd3, 32'hFF);
        in_port = 8'hFF;
        cyc(); cyc();
        wr(3'd3, 32'h04);
        rd_chk("edge_wins", 3'd3, 1'b0, 32'h04);

        // Atomic set/clear
        wr(3'd0, 32'h11);
        wr(3'd4, 32'h06);
`ifdef SRAM_QSYS_GPIO_OUTSETCLR_EN
        check("outset", {24'h0, out_a}, 32'h17);
`else
        check("outset", {24'h0, out_a}, 32'h11);
`endif
        wr(3'd5, 32'h01);
`ifdef SRAM_QSYS_GPIO_OUTSETCLR_EN
        check("outclr", {24'h0, out_a}, 32'h16);
`else
        check("outclr", {24'h0, out_a}, 32'h11);
`endif
        rd_chk("rd4", 3'd4, 1'b0, 32'h0);
        rd_chk("rd5", 3'd5, 1'b0, 32'h0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            reset_n    = ($urandom_range(0, 63) != 0);
            chipselect = $urandom_range(0, 1) == 1;
            write_n    = $urandom_range(0, 1) == 1;
            address    = 3'($urandom_range(0, 7));
            writedata  = $urandom;
            if ($urandom_range(0, 2) == 0) in_port = 8'($urandom);
            cyc();
        end
        chipselect = 1'b0; write_n = 1'b1; reset_n = 1'b1;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
